risc_control_fsm: RTL and testbench
===================================

Name: risc_control_fsm

Overview:
Multi-cycle sequencer for the SimpleRISC accumulator datapath. Takes the IR opcode and the ACC zero flag and drives the control strobes: IR/PC/ACC loads, memory address select, memory read/write and the ALU function code. Owns the fetch/decode/execute state machine. Waits on a memory-ready handshake so variable-latency memory is supported.

Parameters:
OPC_W, 4, opcode width; also the ALU function-code width
(no others; opcode and function values come from the shared opcodes package)

Ports:
Clock  input  1  single system clock, rising edge
nReset  input  1  synchronous active-low reset
Opcode  input  OPC_W  IR[15:12], valid from DECODE onward
Zero  input  1  ACC == 0, from datapath
MemReady  input  1  memory completes the current access this cycle
AddrSel  output  1  0 = PC drives address, 1 = IR operand field drives address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request (ACC is the data)
LoadIR  output  1  capture memory data into IR
IncPC  output  1  PC <= PC + 1
LoadPC  output  1  PC <= IR operand
LoadACC  output  1  ACC <= ALU result
AluFn  output  OPC_W  ALU function code
InstrDone  output  1  one-cycle pulse on the final cycle of each instruction
Halted  output  1  trap state indicator (see Optional Feature)

Behaviour:
- Interface: one clock, Clock. Reset nReset is synchronous and active-low.
- Reset:
  - State register <= FETCH on a Clock edge with nReset=0.
  - While nReset=0, every strobe output is forced to 0 and AluFn = FnACC.
  - Reset mid-access abandons the access; no write completes.
- State register: registered. Outputs are combinational from (state, Opcode, Zero, MemReady). Default strobe value is 0; default AluFn is FnACC.
- FETCH:
  - AddrSel=0, MemRead=1.
  - If MemReady: LoadIR=1, IncPC=1, next state DECODE.
  - Otherwise stay in FETCH, holding the same outputs.
- DECODE (always exactly one cycle):
  - NOP: InstrDone=1, next FETCH.
  - JMP: LoadPC=1, InstrDone=1, next FETCH.
  - JMPZ: LoadPC=Zero, InstrDone=1, next FETCH.
  - JMPNZ: LoadPC=!Zero, InstrDone=1, next FETCH.
  - NOT/LSL/LSR: AluFn=FnNOT/FnLSL/FnLSR, LoadACC=1, InstrDone=1, next FETCH.
  - LDA/ADD/SUB/AND/OR: next MEMRD.
  - STA: next MEMWR.
  - Opcodes 12–14: see Optional Feature.
- MEMRD:
  - AddrSel=1, MemRead=1.
  - AluFn = FnMem for LDA; otherwise FnADD/FnSUB/FnAND/FnOR, matching the opcode.
  - On MemReady: LoadACC=1, InstrDone=1, next FETCH. Otherwise hold.
- MEMWR:
  - AddrSel=1, MemWrite=1, AluFn=FnACC.
  - On MemReady: InstrDone=1, next FETCH. Otherwise hold.
- Input timing: Opcode is sampled only in DECODE/MEMRD/MEMWR. IR is stable there because LoadIR pulses only in FETCH.
- Latency with MemReady tied high:
  - NOP, jumps, NOT/LSL/LSR: 2 cycles.
  - LDA, ADD, SUB, AND, OR, STA: 3 cycles.
  - Each cycle MemReady is low adds one cycle.
- Mutual exclusion: MemRead and MemWrite are never both 1. LoadPC and IncPC are never both 1.
- Zero is sampled in DECODE only. Its value in other states is don't-care.

Optional Feature:
Macro RISC_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 12–14 in DECODE go to HALT, with no InstrDone pulse.
  - HALT: all strobes 0, Halted=1. Stays in HALT until nReset=0.
- Undefined:
  - Opcodes 12–14 decode as NOP: InstrDone=1, next FETCH.
  - HALT state does not exist; Halted is tied to 0.

Decomposition:
- Shared package (the opcodes package, extended):
  - typedef enum ctrl_state_t {FETCH, DECODE, MEMRD, MEMWR, HALT}
  - ADDR_PC=1'b0, ADDR_IR=1'b1
  - OPC_W
  - existing opcode and ALU function constants (FnACC, FnMem, FnADD, FnSUB, FnAND, FnOR, FnNOT, FnLSL, FnLSR)
- Optional sub-module risc_op_class: combinational. Maps Opcode to {is_jump, is_reg_alu, is_mem_rd, is_store, is_illegal} plus the AluFn value. The FSM instantiates it once.

Test Plan:
1. nReset=0 for 2 cycles while MemReady=1, then release -> all strobes 0 during reset. First post-reset cycle: AddrSel=0, MemRead=1, LoadIR=1, IncPC=1.
2. MemReady=1, Opcode=ADD(5) -> cycle1 FETCH, cycle2 DECODE, cycle3 MemRead=1, AddrSel=1, AluFn=5, LoadACC=1, InstrDone=1.
3. Opcode=STA(15), MemReady low for 3 cycles in MEMWR -> MemWrite=1 held 4 cycles, InstrDone only on the 4th, LoadACC never asserted.
4. Opcode=JMPZ(2): Zero=1 -> LoadPC=1 in DECODE. Repeat with Zero=0 -> LoadPC=0. Both take 2 cycles with InstrDone=1.
5. Opcode=LSR(11) -> DECODE cycle: AluFn=11, LoadACC=1, no MemRead. Then nReset=0 asserted during the next FETCH stall -> the following cycle is FETCH with all strobes 0 until release.
6. Opcode=13: with RISC_ILLEGAL_TRAP_EN -> Halted=1 permanently, no strobes, no InstrDone, until reset. Without it -> InstrDone=1 in DECODE, then FETCH.

Source files
------------

// File: rtl/risc_control_fsm_pkg.sv
// Shared SimpleRISC opcode, ALU function and sequencer-state definitions.
package risc_control_fsm_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEMRD  = 3'd2,
    MEMWR  = 3'd3,
    HALT   = 3'd4
  } ctrl_state_t;

  localparam logic ADDR_PC = 1'b0;
  localparam logic ADDR_IR = 1'b1;

  localparam logic [OPC_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'd1;
  localparam logic [OPC_W-1:0] OP_JMPZ  = 4'd2;
  localparam logic [OPC_W-1:0] OP_JMPNZ = 4'd3;
  localparam logic [OPC_W-1:0] OP_LDA   = 4'd4;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'd5;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'd6;
  localparam logic [OPC_W-1:0] OP_AND   = 4'd7;
  localparam logic [OPC_W-1:0] OP_OR    = 4'd8;
  localparam logic [OPC_W-1:0] OP_NOT   = 4'd9;
  localparam logic [OPC_W-1:0] OP_LSL   = 4'd10;
  localparam logic [OPC_W-1:0] OP_LSR   = 4'd11;
  localparam logic [OPC_W-1:0] OP_STA   = 4'd15;

  // ALU codes for real operations share the opcode value; FnMem passes memory data through.
  localparam logic [OPC_W-1:0] FnACC = 4'd0;
  localparam logic [OPC_W-1:0] FnMem = 4'd4;
  localparam logic [OPC_W-1:0] FnADD = 4'd5;
  localparam logic [OPC_W-1:0] FnSUB = 4'd6;
  localparam logic [OPC_W-1:0] FnAND = 4'd7;
  localparam logic [OPC_W-1:0] FnOR  = 4'd8;
  localparam logic [OPC_W-1:0] FnNOT = 4'd9;
  localparam logic [OPC_W-1:0] FnLSL = 4'd10;
  localparam logic [OPC_W-1:0] FnLSR = 4'd11;

endpackage

// File: rtl/risc_control_fsm_op_class.sv
// Combinational opcode classifier: instruction category flags plus the ALU function it needs.
module risc_op_class #(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode_i,
  output logic             is_jump_o,
  output logic             is_reg_alu_o,
  output logic             is_mem_rd_o,
  output logic             is_store_o,
  output logic             is_illegal_o,
  output logic [OPC_W-1:0] alu_fn_o
);
  import risc_control_fsm_pkg::*;

  always_comb begin
    is_jump_o    = 1'b0;
    is_reg_alu_o = 1'b0;
    is_mem_rd_o  = 1'b0;
    is_store_o   = 1'b0;
    is_illegal_o = 1'b0;
    alu_fn_o     = FnACC;
    case (opcode_i)
      OP_JMP, OP_JMPZ, OP_JMPNZ: is_jump_o = 1'b1;
      OP_NOT: begin is_reg_alu_o = 1'b1; alu_fn_o = FnNOT; end
      OP_LSL: begin is_reg_alu_o = 1'b1; alu_fn_o = FnLSL; end
      OP_LSR: begin is_reg_alu_o = 1'b1; alu_fn_o = FnLSR; end
      OP_LDA: begin is_mem_rd_o  = 1'b1; alu_fn_o = FnMem; end
      OP_ADD: begin is_mem_rd_o  = 1'b1; alu_fn_o = FnADD; end
      OP_SUB: begin is_mem_rd_o  = 1'b1; alu_fn_o = FnSUB; end
      OP_AND: begin is_mem_rd_o  = 1'b1; alu_fn_o = FnAND; end
      OP_OR:  begin is_mem_rd_o  = 1'b1; alu_fn_o = FnOR;  end
      OP_STA: is_store_o = 1'b1;
      4'd12, 4'd13, 4'd14: is_illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/risc_control_fsm.sv
// SimpleRISC fetch/decode/execute sequencer with memory-ready handshake.
// Define RISC_ILLEGAL_TRAP_EN to trap opcodes 12-14 into a HALT state.
module risc_control_fsm #(
  parameter int OPC_W = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             AddrSel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             LoadPC,
  output logic             LoadACC,
  output logic [OPC_W-1:0] AluFn,
  output logic             InstrDone,
  output logic             Halted
);
  import risc_control_fsm_pkg::*;

  ctrl_state_t      state_q, state_d;
  logic             is_jump, is_reg_alu, is_mem_rd, is_store, is_illegal;
  logic [OPC_W-1:0] op_fn;

  risc_op_class #(.OPC_W(OPC_W)) u_op_class (
    .opcode_i     (Opcode),
    .is_jump_o    (is_jump),
    .is_reg_alu_o (is_reg_alu),
    .is_mem_rd_o  (is_mem_rd),
    .is_store_o   (is_store),
    .is_illegal_o (is_illegal),
    .alu_fn_o     (op_fn)
  );

  always_ff @(posedge Clock) begin
    if (!nReset) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Outputs are gated by nReset so an in-flight access is dropped the cycle reset is seen.
  always_comb begin
    state_d   = state_q;
    AddrSel   = ADDR_PC;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    LoadIR    = 1'b0;
    IncPC     = 1'b0;
    LoadPC    = 1'b0;
    LoadACC   = 1'b0;
    AluFn     = FnACC;
    InstrDone = 1'b0;
    Halted    = 1'b0;
    if (nReset) begin
      unique case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          if (MemReady) begin
            LoadIR  = 1'b1;
            IncPC   = 1'b1;
            state_d = DECODE;
          end
        end
        DECODE: begin
          state_d = FETCH;
          if (is_mem_rd) begin
            state_d = MEMRD;
          end else if (is_store) begin
            state_d = MEMWR;
          end else if (is_illegal) begin
`ifdef RISC_ILLEGAL_TRAP_EN
            state_d = HALT;
`else
            InstrDone = 1'b1;
`endif
          end else begin
            InstrDone = 1'b1;
            if (is_jump) begin
              LoadPC = (Opcode == OP_JMP) ||
                       ((Opcode == OP_JMPZ) && Zero) ||
                       ((Opcode == OP_JMPNZ) && !Zero);
            end
            if (is_reg_alu) begin
              AluFn   = op_fn;
              LoadACC = 1'b1;
            end
          end
        end
        MEMRD: begin
          AddrSel = ADDR_IR;
          MemRead = 1'b1;
          AluFn   = op_fn;
          if (MemReady) begin
            LoadACC   = 1'b1;
            InstrDone = 1'b1;
            state_d   = FETCH;
          end
        end
        MEMWR: begin
          AddrSel  = ADDR_IR;
          MemWrite = 1'b1;
          if (MemReady) begin
            InstrDone = 1'b1;
            state_d   = FETCH;
          end
        end
        HALT: begin
`ifdef RISC_ILLEGAL_TRAP_EN
          Halted = 1'b1;
`else
          state_d = FETCH;
`endif
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
// Instruction-level self-checking bench for risc_control_fsm (directed + randomized).
module tb_risc_control_fsm;
  localparam int OPC_W = 4;

  logic             Clock = 1'b0;
  logic             nReset;
  logic [OPC_W-1:0] Opcode;
  logic             Zero;
  logic             MemReady;
  logic             AddrSel, MemRead, MemWrite, LoadIR, IncPC, LoadPC, LoadACC;
  logic [OPC_W-1:0] AluFn;
  logic             InstrDone, Halted;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  risc_control_fsm #(.OPC_W(OPC_W)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .AddrSel   (AddrSel),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .LoadIR    (LoadIR),
    .IncPC     (IncPC),
    .LoadPC    (LoadPC),
    .LoadACC   (LoadACC),
    .AluFn     (AluFn),
    .InstrDone (InstrDone),
    .Halted    (Halted)
  );

  logic [12:0] obs;
  assign obs = {AddrSel, MemRead, MemWrite, LoadIR, IncPC, LoadPC, LoadACC, InstrDone, Halted, AluFn};

  // Expected output vector, same field order as obs.
  function automatic logic [12:0] vec(input bit a, input bit rd, input bit wr, input bit ir,
                                      input bit inc, input bit pc, input bit acc, input bit done,
                                      input bit halt, input logic [3:0] fn);
    return {a, rd, wr, ir, inc, pc, acc, done, halt, fn};
  endfunction

  function automatic bit is_illegal_opc(input logic [3:0] opc);
    return (opc >= 4'd12) && (opc <= 4'd14);
  endfunction

  // Reference behaviour of the decode cycle, straight from the instruction table.
  function automatic logic [12:0] decode_exp(input logic [3:0] opc, input bit z);
    logic [12:0] e;
    e = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    if (opc == 4'd0) e = vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
    else if (opc == 4'd1) e = vec(0, 0, 0, 0, 0, 1, 0, 1, 0, 4'd0);
    else if (opc == 4'd2) e = vec(0, 0, 0, 0, 0, z, 0, 1, 0, 4'd0);
    else if (opc == 4'd3) e = vec(0, 0, 0, 0, 0, !z, 0, 1, 0, 4'd0);
    else if (opc >= 4'd9 && opc <= 4'd11) e = vec(0, 0, 0, 0, 0, 0, 1, 1, 0, opc);
    else if (is_illegal_opc(opc)) begin
`ifdef RISC_ILLEGAL_TRAP_EN
      e = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
`else
      e = vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'd0);
`endif
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    nReset = 1'b0;
    for (int i = 0; i < n; i++) begin
      MemReady = 1'b1;
      Opcode   = 4'($urandom);
      Zero     = 1'($urandom);
      #2;
      check("reset", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0));
      tick();
    end
    nReset = 1'b1;
  endtask

  task automatic do_fetch(input int fst);
    for (int i = 0; i <= fst; i++) begin
      MemReady = (i == fst);
      Opcode   = 4'($urandom);
      Zero     = 1'($urandom);
      #2;
      check("fetch", vec(0, 1, 0, MemReady, MemReady, 0, 0, 0, 0, 4'd0));
      tick();
    end
  endtask

  // One full instruction: fetch with fst stall cycles, decode, then memory phase with mst stalls.
  task automatic run_instr(input logic [3:0] opc, input bit z, input int fst, input int mst);
    logic [3:0] fn;
    do_fetch(fst);
    Opcode   = opc;
    Zero     = z;
    MemReady = 1'($urandom);
    #2;
    check("decode", decode_exp(opc, z));
    tick();
    if (opc >= 4'd4 && opc <= 4'd8) begin
      fn = (opc == 4'd4) ? 4'd4 : opc;
      for (int i = 0; i <= mst; i++) begin
        MemReady = (i == mst);
        Zero     = 1'($urandom);
        #2;
        check("memrd", vec(1, 1, 0, 0, 0, 0, MemReady, MemReady, 0, fn));
        tick();
      end
    end else if (opc == 4'd15) begin
      for (int i = 0; i <= mst; i++) begin
        MemReady = (i == mst);
        Zero     = 1'($urandom);
        #2;
        check("memwr", vec(1, 0, 1, 0, 0, 0, 0, MemReady, 0, 4'd0));
        tick();
      end
    end
  endtask

  initial begin
    logic [3:0] opc;
    nReset = 1'b0; Opcode = 4'd0; Zero = 1'b0; MemReady = 1'b1;
    #1;

    do_reset(2);
    run_instr(4'd5, 1'b0, 0, 0);
    run_instr(4'd15, 1'b0, 0, 3);
    run_instr(4'd2, 1'b1, 0, 0);
    run_instr(4'd2, 1'b0, 0, 0);
    run_instr(4'd3, 1'b0, 1, 0);
    run_instr(4'd4, 1'b1, 2, 1);
    run_instr(4'd11, 1'b0, 0, 0);

    // Reset during a fetch stall.
    MemReady = 1'b0;
    #2;
    check("fetch_stall", vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'd0));
    tick();
    do_reset(2);
    run_instr(4'd1, 1'b0, 0, 0);

    // Reset during a stalled store: the access is dropped and FETCH resumes.
    do_fetch(0);
    Opcode = 4'd15; MemReady = 1'b0;
    #2;
    check("sta_decode", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0));
    tick();
    #2;
    check("sta_stall", vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0));
    tick();
    do_reset(1);
    run_instr(4'd0, 1'b0, 0, 0);

    // Illegal opcode 13.
`ifdef RISC_ILLEGAL_TRAP_EN
    run_instr(4'd13, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      MemReady = 1'($urandom);
      Opcode   = 4'($urandom);
      Zero     = 1'($urandom);
      #2;
      check("halt", vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'd0));
      tick();
    end
    do_reset(1);
`else
    run_instr(4'd13, 1'b0, 0, 0);
`endif
    run_instr(4'd9, 1'b1, 0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 120; n++) begin
      opc = 4'($urandom);
`ifdef RISC_ILLEGAL_TRAP_EN
      if (is_illegal_opc(opc)) opc = 4'd0;
`endif
      run_instr(opc, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
